// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: sync, glitch filter, frame FSM, prefix fold, FWFT FIFO.
// Define PS2_RX_PARITY_EN to enable odd-parity checking.
module ps2_rx_fifo #(
   parameter int FILTER_LEN     = 16,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          kclk,
   input  logic                          kdata,
   output logic [7:0]                    key_code,
   output logic                          key_ext,
   output logic                          key_break,
   output logic                          key_valid,
   input  logic                          key_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    s1, s2, filt;
   logic [CW-1:0] fcnt [2];
   logic          kfall;

   // Index 0 is kclk, index 1 is kdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 2'b11;
         s2    <= 2'b11;
         filt  <= 2'b11;
         kfall <= 1'b0;
         for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      end else begin
         s1    <= {kdata, kclk};
         s2    <= s1;
         kfall <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
               fcnt[i] <= '0;
               filt[i] <= s2[i];
               if (i == 0 && !s2[i]) kfall <= 1'b1;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   wire kd = filt[1];

   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [7:0]    rx_byte;
   logic          par_ok;
   logic          byte_done;
   logic [TW-1:0] tcnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_byte   <= '0;
         par_ok    <= 1'b0;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
         tcnt      <= '0;
      end else begin
         byte_done <= 1'b0;
         frame_err <= 1'b0;
         if (kfall || state == IDLE) tcnt <= '0;
         else                        tcnt <= tcnt + 1'b1;
         if (state != IDLE && !kfall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            frame_err <= 1'b1;
         end else if (kfall) begin
            unique case (state)
               IDLE: begin
                  if (!kd) state <= DATA;
                  bit_cnt <= '0;
               end
               DATA: begin
                  shreg   <= {kd, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
`ifdef PS2_RX_PARITY_EN
                  par_ok <= ^{shreg, kd};
`else
                  par_ok <= 1'b1;
`endif
                  state <= STOP;
               end
               STOP: begin
                  if (kd && par_ok) begin
                     byte_done <= 1'b1;
                     rx_byte   <= shreg;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   logic ext, brk;
   wire  is_pre = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
   wire  push   = byte_done && !is_pre;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (frame_err || push) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (byte_done) begin
         if (rx_byte == 8'hE0) ext <= 1'b1;
         if (rx_byte == 8'hF0) brk <= 1'b1;
      end
   end

   logic [9:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   wire full   = (count == (AW+1)'(FIFO_DEPTH));
   wire pop    = key_valid && key_ready;
   wire do_wr  = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= {ext, brk, rx_byte};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push && full && !pop;
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (do_wr && !pop)      count <= count + 1'b1;
         else if (pop && !do_wr) count <= count - 1'b1;
      end
   end

   wire [9:0] head = mem[rd_ptr];

   assign key_valid  = (count != '0);
   assign fifo_count = count;
   assign key_code   = key_valid ? head[7:0] : 8'h00;
   assign key_break  = key_valid ? head[8]   : 1'b0;
   assign key_ext    = key_valid ? head[9]   : 1'b0;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo with shortened filter/timeout and a 4-deep FIFO.
module tb_ps2_rx_fifo;

   localparam int FL = 4;
   localparam int TO = 2000;
   localparam int D  = 4;

   logic       clk = 0;
   logic       rst = 1;
   logic       kclk = 1;
   logic       kdata = 1;
   logic       key_ready = 0;
   logic [7:0] key_code;
   logic       key_ext, key_break, key_valid;
   logic [$clog2(D):0] fifo_count;
   logic       frame_err, overflow;

   int total = 0;
   int passed = 0;
   int failed = 0;
   int err_cnt = 0;
   int ovf_cnt = 0;
   int saved_err, saved_ovf;

   ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata),
      .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
      .key_valid(key_valid), .key_ready(key_ready),
      .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) err_cnt++;
      if (overflow)  ovf_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input logic glitch);
      kdata = b;
      cyc(5);
      if (glitch) begin
         kclk = 0;
         cyc(2);
         kclk = 1;
      end
      cyc(5);
      kclk = 0;
      cyc(20);
      kclk = 1;
      cyc(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic badpar,
                             input logic glitch);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
      send_bit((~^b) ^ badpar, 1'b0);
      send_bit(1'b1, 1'b0);
      kdata = 1;
      cyc(5);
   endtask

   task automatic pop1();
      key_ready = 1;
      cyc(1);
      key_ready = 0;
   endtask

   logic [7:0] codes [5];

   initial begin
      codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24;
      codes[3] = 8'h2D; codes[4] = 8'h2C;

      cyc(3);
      check("rst_valid", key_valid, 0);
      check("rst_code", key_code, 0);
      check("rst_count", fifo_count, 0);
      check("rst_err", frame_err, 0);
      check("rst_ovf", overflow, 0);
      rst = 0;
      cyc(30);

      send_frame(8'h1C, 0, 0);
      check("t1_valid", key_valid, 1);
      check("t1_code", key_code, 8'h1C);
      check("t1_ext", key_ext, 0);
      check("t1_brk", key_break, 0);
      check("t1_count", fifo_count, 1);
      pop1();
      check("t1_popcnt", fifo_count, 0);
      check("t1_popval", key_valid, 0);

      send_frame(8'hE0, 0, 0);
      send_frame(8'hF0, 0, 0);
      check("t2_nopush", fifo_count, 0);
      send_frame(8'h75, 0, 0);
      check("t2_count", fifo_count, 1);
      check("t2_code", key_code, 8'h75);
      check("t2_ext", key_ext, 1);
      check("t2_brk", key_break, 1);
      pop1();
      send_frame(8'h1C, 0, 0);
      check("t2_clr_ext", key_ext, 0);
      check("t2_clr_brk", key_break, 0);
      pop1();

      send_frame(8'hE1, 0, 0);
      check("e1_code", key_code, 8'hE1);
      check("e1_ext", key_ext, 0);
      pop1();

      saved_ovf = ovf_cnt;
      for (int i = 0; i < 5; i++) send_frame(codes[i], 0, 0);
      check("t3_count", fifo_count, D);
      check("t3_ovf", ovf_cnt - saved_ovf, 1);
      for (int i = 0; i < D; i++) begin
         check($sformatf("t3_code%0d", i), key_code, codes[i]);
         pop1();
      end
      check("t3_empty", key_valid, 0);

      saved_err = err_cnt;
      send_frame(8'hE0, 0, 0);
      for (int i = 0; i < 5; i++) send_bit(i[0], 0);
      cyc(TO + 50);
      check("t4_err", err_cnt - saved_err, 1);
      check("t4_noentry", fifo_count, 0);
      send_frame(8'h29, 0, 0);
      check("t4_code", key_code, 8'h29);
      check("t4_ext", key_ext, 0);
      check("t4_err2", err_cnt - saved_err, 1);
      pop1();

      saved_err = err_cnt;
      send_frame(8'h1C, 1, 0);
`ifdef PS2_RX_PARITY_EN
      check("t5_err", err_cnt - saved_err, 1);
      check("t5_count", fifo_count, 0);
`else
      check("t5_err", err_cnt - saved_err, 0);
      check("t5_code", key_code, 8'h1C);
      pop1();
`endif

      send_frame(8'h5A, 0, 1);
      check("t6_glitch", key_code, 8'h5A);
      check("t6_gcount", fifo_count, 1);

      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      saved_err = err_cnt;
      saved_ovf = ovf_cnt;
      rst = 1;
      #1;
      check("t6_rvalid", key_valid, 0);
      check("t6_rcount", fifo_count, 0);
      check("t6_rcode", key_code, 0);
      cyc(3);
      kdata = 1;
      rst = 0;
      cyc(TO + 50);
      check("t6_nopulse", err_cnt - saved_err, 0);
      check("t6_noovf", ovf_cnt - saved_ovf, 0);
      send_frame(8'h1C, 0, 0);
      check("t6_after", key_code, 8'h1C);
      check("t6_acount", fifo_count, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
